// File: rtl/writeback_stage.sv
// Final writeback stage: formats retired results, queues them, and issues
// paced single-cycle register-file write pulses to the storer.
module writeback_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wb_en,
  input  logic [4:0]       in_rd,
  input  logic             in_sel,
  input  logic [31:0]      in_alu,
  input  logic [31:0]      in_mem,
  input  logic [1:0]       in_size,
  input  logic             in_unsigned,
  input  logic [1:0]       in_addr_lo,
  output logic             we,
  output logic [4:0]       wa,
  output logic [31:0]      wd,
  input  logic             wr,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] wb_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);
  localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              we_q, we_d;
  logic [4:0]        wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;

  logic [4:0]  fifo_wa_mem [DEPTH];
  logic [31:0] fifo_wd_mem [DEPTH];

  logic [7:0]  byte_lane [4];
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] fmt_data;
  logic        misaligned;
  logic        writes_reg;
  logic        accept;
  logic        push;
  logic        pop;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = in_mem[8*gi +: 8];
    end
  endgenerate

  // Result formatting happens before enqueue so the FIFO only holds final data.
  always_comb begin
    load_byte = byte_lane[in_addr_lo];
    load_half = in_addr_lo[1] ? in_mem[31:16] : in_mem[15:0];
    fmt_data  = in_alu;
    if (in_sel) begin
      case (in_size)
        2'b00:   fmt_data = in_unsigned ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
        2'b01:   fmt_data = in_unsigned ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
        default: fmt_data = in_mem;
      endcase
    end
  end

  assign misaligned = in_sel && ((in_size == 2'b11) ||
                                 (in_size == 2'b01 && in_addr_lo[0]) ||
                                 (in_size == 2'b10 && in_addr_lo != 2'b00));
  assign writes_reg = in_wb_en && (in_rd != 5'd0);
  assign in_ready   = (count_q < FULL_CNT);
  assign accept     = in_valid && in_ready;
  assign push       = accept && writes_reg && !misaligned;

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    pop        = 1'b0;
    wb_count_d = wb_count_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && wr) begin
          pop        = 1'b1;
          we_d       = 1'b1;
          wa_d       = fifo_wa_mem[rd_ptr_q];
          wd_d       = fifo_wd_mem[rd_ptr_q];
          wb_count_d = wb_count_q + CNT_W'(1);
          state_d    = S_PULSE;
        end
      end
      S_PULSE: state_d = S_WAIT;
      // The storer drops wr after each write, so this gates the next issue.
      S_WAIT:  if (wr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = accept && writes_reg && misaligned;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa_mem[wr_ptr_q] <= in_rd;
      fifo_wd_mem[wr_ptr_q] <= fmt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      wb_count_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      we_q       <= we_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      wb_count_q <= wb_count_d;
    end
  end

  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign err      = err_q;
  assign wb_count = wb_count_q;
  assign busy     = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a small storer model that drops wr
// for the cycle after each write and keeps a register file.
module tb_writeback_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_wb_en;
  logic [4:0]       in_rd;
  logic             in_sel;
  logic [31:0]      in_alu;
  logic [31:0]      in_mem;
  logic [1:0]       in_size;
  logic             in_unsigned;
  logic [1:0]       in_addr_lo;
  logic             we;
  logic [4:0]       wa;
  logic [31:0]      wd;
  logic             wr;
  logic             err;
  logic             busy;
  logic [CNT_W-1:0] wb_count;

  logic        wr_en;
  logic        rf_clear;
  logic        storer_busy;
  logic [31:0] regfile [32];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_we  = -1;
  int n_we     = 0;
  logic prev_wr = 1'b0;
  logic [4:0]  wa_log [$];
  logic [31:0] wd_log [$];

  writeback_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu),
    .in_mem(in_mem), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr_lo(in_addr_lo), .we(we), .wa(wa), .wd(wd), .wr(wr),
    .err(err), .busy(busy), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  assign wr = wr_en && !storer_busy;

  // Storer model: commits each pulse and is not ready the following cycle.
  always @(posedge clk) begin
    if (rf_clear) begin
      storer_busy <= 1'b0;
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else begin
      storer_busy <= (we === 1'b1);
      if (we === 1'b1) regfile[wa] <= wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (we === 1'b1) begin
      chk("wr_before_we", {31'b0, prev_wr}, 32'd1);
      if (last_we >= 0) chk("we_spacing_ge3", {31'b0, (cyc - last_we) >= 3}, 32'd1);
      last_we = cyc;
      n_we++;
      wa_log.push_back(wa);
      wd_log.push_back(wd);
      $display("write %0d: wa=%0d wd=%h wb_count=%0d", n_we, wa, wd, wb_count);
    end
    prev_wr = wr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wb, input logic [4:0] rd, input logic sel,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic [1:0] size, input logic uns, input logic [1:0] lo);
    int waited;
    in_wb_en = wb; in_rd = rd; in_sel = sel; in_alu = alu; in_mem = mem;
    in_size = size; in_unsigned = uns; in_addr_lo = lo; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 40) begin
      step();
      waited++;
    end
    chk("push_ready", {31'b0, in_ready}, 32'd1);
    if (in_ready) step();
    in_valid = 1'b0;
    $display("push rd=%0d sel=%0d size=%0d lo=%0d accepted after %0d stalls", rd, sel, size, lo, waited);
  endtask

  task automatic expect_write(input string tag, input logic [4:0] ewa, input logic [31:0] ewd);
    int t;
    t = 0;
    while (wa_log.size() == 0 && t < 60) begin
      step();
      t++;
    end
    chk({tag, "_seen"}, {31'b0, wa_log.size() != 0}, 32'd1);
    if (wa_log.size() != 0) begin
      chk({tag, "_wa"}, {27'b0, wa_log.pop_front()}, {27'b0, ewa});
      chk({tag, "_wd"}, wd_log.pop_front(), ewd);
    end
  endtask

  initial begin
    int we_before;
    reset = 1'b1; rf_clear = 1'b1; wr_en = 1'b1; in_valid = 1'b0;
    in_wb_en = 1'b0; in_rd = '0; in_sel = 1'b0; in_alu = '0; in_mem = '0;
    in_size = 2'b10; in_unsigned = 1'b0; in_addr_lo = '0;
    repeat (3) step();
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_wa", {27'b0, wa}, 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wb_count", wb_count, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0; rf_clear = 1'b0;
    step();

    // ALU write with exact latency
    push(1'b1, 5'd5, 1'b0, 32'hDEADBEEF, 32'h0, 2'b10, 1'b0, 2'd0);
    chk("alu_we_not_yet", {31'b0, we}, 32'd0);
    step();
    chk("alu_we_latency", {31'b0, we}, 32'd1);
    chk("alu_wa", {27'b0, wa}, 32'd5);
    chk("alu_wd", wd, 32'hDEADBEEF);
    chk("alu_wb_count", wb_count, 32'd1);
    step();
    chk("alu_we_one_cycle", {31'b0, we}, 32'd0);
    expect_write("alu", 5'd5, 32'hDEADBEEF);

    // Load extension
    push(1'b1, 5'd6, 1'b1, 32'h0, 32'h80FF7F01, 2'b00, 1'b0, 2'd3);
    push(1'b1, 5'd7, 1'b1, 32'h0, 32'h80FF7F01, 2'b01, 1'b1, 2'd2);
    expect_write("ld_byte_s", 5'd6, 32'hFFFFFF80);
    expect_write("ld_half_u", 5'd7, 32'h000080FF);
    chk("ld_wb_count", wb_count, 32'd3);

    // Drops
    we_before = n_we;
    push(1'b1, 5'd0, 1'b0, 32'h12345678, 32'h0, 2'b10, 1'b0, 2'd0);
    chk("drop_x0_err", {31'b0, err}, 32'd0);
    push(1'b0, 5'd9, 1'b0, 32'h12345678, 32'h0, 2'b10, 1'b0, 2'd0);
    chk("drop_nowb_err", {31'b0, err}, 32'd0);
    push(1'b1, 5'd10, 1'b1, 32'h0, 32'hAABBCCDD, 2'b01, 1'b0, 2'd1);
    chk("drop_half_err", {31'b0, err}, 32'd1);
    step();
    chk("drop_half_err_end", {31'b0, err}, 32'd0);
    push(1'b1, 5'd11, 1'b1, 32'h0, 32'hAABBCCDD, 2'b10, 1'b0, 2'd2);
    chk("drop_word_err", {31'b0, err}, 32'd1);
    push(1'b1, 5'd0, 1'b1, 32'h0, 32'hAABBCCDD, 2'b11, 1'b0, 2'd0);
    chk("drop_x0_rsvd_err", {31'b0, err}, 32'd0);
    repeat (12) step();
    chk("drop_no_we", n_we, we_before);
    chk("drop_wb_count", wb_count, 32'd3);
    chk("drop_busy", {31'b0, busy}, 32'd0);

    // Back-pressure
    wr_en = 1'b0;
    push(1'b1, 5'd1, 1'b0, 32'h11111111, 32'h0, 2'b10, 1'b0, 2'd0);
    chk("bp_ready_1", {31'b0, in_ready}, 32'd1);
    push(1'b1, 5'd2, 1'b0, 32'h22222222, 32'h0, 2'b10, 1'b0, 2'd0);
    chk("bp_ready_full", {31'b0, in_ready}, 32'd0);
    repeat (3) step();
    chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_busy", {31'b0, busy}, 32'd1);
    wr_en = 1'b1;
    push(1'b1, 5'd3, 1'b1, 32'h0, 32'hCAFEF00D, 2'b10, 1'b0, 2'd0);
    expect_write("bp_a", 5'd1, 32'h11111111);
    expect_write("bp_b", 5'd2, 32'h22222222);
    expect_write("bp_c", 5'd3, 32'hCAFEF00D);

    // Storer pacing, continuous stream
    push(1'b1, 5'd20, 1'b1, 32'h0, 32'h1234F6CD, 2'b00, 1'b1, 2'd1);
    push(1'b1, 5'd21, 1'b1, 32'h0, 32'h1234F6CD, 2'b01, 1'b0, 2'd0);
    push(1'b1, 5'd22, 1'b0, 32'h0BADF00D, 32'h0, 2'b10, 1'b0, 2'd0);
    push(1'b1, 5'd23, 1'b1, 32'h0, 32'h0000007F, 2'b00, 1'b0, 2'd0);
    expect_write("pace_0", 5'd20, 32'h000000F6);
    expect_write("pace_1", 5'd21, 32'hFFFFF6CD);
    expect_write("pace_2", 5'd22, 32'h0BADF00D);
    expect_write("pace_3", 5'd23, 32'h0000007F);
    repeat (3) step();
    chk("rf_20", regfile[20], 32'h000000F6);
    chk("rf_21", regfile[21], 32'hFFFFF6CD);
    chk("rf_22", regfile[22], 32'h0BADF00D);
    chk("rf_23", regfile[23], 32'h0000007F);
    chk("pace_wb_count", wb_count, 32'd10);

    // Reset mid-stream: one write in flight, one queued
    wr_en = 1'b0;
    repeat (4) step();
    push(1'b1, 5'd24, 1'b0, 32'hAAAA0001, 32'h0, 2'b10, 1'b0, 2'd0);
    push(1'b1, 5'd25, 1'b0, 32'hBBBB0002, 32'h0, 2'b10, 1'b0, 2'd0);
    wr_en = 1'b1;
    step();
    chk("mid_pulse_we", {31'b0, we}, 32'd1);
    chk("mid_pulse_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    in_wb_en = 1'b1; in_rd = 5'd26; in_sel = 1'b0; in_alu = 32'hCCCC0003; in_valid = 1'b1;
    step();
    chk("mid_rst_we", {31'b0, we}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_wb_count", wb_count, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    expect_write("mid_inflight", 5'd24, 32'hAAAA0001);
    we_before = n_we;
    repeat (15) step();
    chk("mid_no_more_we", n_we, we_before);
    chk("mid_rf_25", regfile[25], 32'h0);
    chk("mid_rf_26", regfile[26], 32'h0);
    chk("mid_final_busy", {31'b0, busy}, 32'd0);
    chk("mid_final_wb_count", wb_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
